dm_controller: RTL and testbench
================================

# dm_controller

Data-memory access controller for the 16-bit five-stage pipeline. It replaces the behavioural data-memory model in the MEM stage, consuming the registered EXE/MEM outputs (address, write data, read/write strobes). It sequences the asynchronous Ram1 SRAM and the memory-mapped UART, stalls the pipeline until each access completes, and returns read data to the MEM/WB register.

## Interface
Parameters:
- ADDR_W, 18, SRAM address width; the 16-bit CPU address is zero-extended.
- UART_DATA_ADDR, 16'hBF00, UART data register address.
- UART_STAT_ADDR, 16'hBF01, UART status register address.

Ports:
- clk  in  1  pipeline clock, single clock domain.
- rst  in  1  asynchronous, active-low reset.
- mem_read  in  1  load request from EXE/MEM.
- mem_write  in  1  store request from EXE/MEM.
- mem_address  in  16  access address.
- mem_wdata  in  16  store data.
- mem_readdata  out  16  load result, registered.
- mem_ack  out  1  one-cycle pulse when the access completes.
- mem_stall  out  1  combinational; freezes PC, IF/ID, ID/EXE and EXE/MEM.
- ram_addr  out  ADDR_W  SRAM address.
- ram_data  inout  16  SRAM/UART shared data bus.
- ram_en_n, ram_oe_n, ram_we_n  out  1 each  SRAM strobes, active-low.
- uart_rdn, uart_wrn  out  1 each  UART strobes, active-low.
- uart_data_ready, uart_tbre, uart_tsre  in  1 each  UART status.

## Operation
- req = mem_read | mem_write. If both are high, the access is a write and mem_readdata is unchanged.
- mem_stall = req & ~mem_ack. EXE/MEM holds its inputs stable while the stall is high.
- Decode: addr == UART_DATA_ADDR selects UART; addr == UART_STAT_ADDR selects STAT; any other address selects SRAM.
- FSM states: IDLE, SR_RD, SW_SET, SW_PULSE, SW_HOLD, UR_PULSE, UW_PULSE, UW_WAIT, DONE.
- IDLE: with no request, all strobes are high and the bus is tri-stated.
- IDLE to SR_RD (SRAM read): addr driven, en_n=0, oe_n=0. SR_RD samples ram_data into mem_readdata, then goes to DONE.
- IDLE to SW_SET (SRAM write): addr and data driven, en_n=0. SW_PULSE: we_n=0. SW_HOLD: we_n=1, data still driven. Then DONE.
- STAT read is served inside IDLE with no bus cycle: mem_readdata = {14'b0, uart_data_ready, uart_tbre & uart_tsre}, then go to DONE.
- UART read: IDLE to UR_PULSE with rdn=0 and the bus tri-stated. UR_PULSE samples ram_data[7:0] zero-extended, then rdn=1 and go to DONE.
- UART write: IDLE to UW_PULSE with data driven and wrn=0. UW_PULSE releases wrn and goes to UW_WAIT. UW_WAIT holds until uart_tsre=1, then goes to DONE.
- DONE: mem_ack=1, all strobes are high, return to IDLE. A request present in the following IDLE cycle is treated as a new access.
- A store to STAT is ignored: IDLE goes directly to DONE.
- SRAM and UART are never enabled in the same cycle. Whenever a UART strobe is low, ram_en_n is 1.

## Timing
- Reset values: mem_readdata=0, mem_ack=0, every strobe=1, ram_addr=0, bus tri-stated, state=IDLE.
- Reset asserted mid-access: strobes deassert asynchronously and no ack is issued.
- Latency from request seen in IDLE to mem_ack, in cycles: SRAM read 2, SRAM write 4, STAT 1 (ack on the next edge), UART read 2, UART write 3 + tsre wait.
- mem_readdata is valid in the mem_ack cycle and holds until the next load completes.
- ram_data is driven only in SW_SET, SW_PULSE, SW_HOLD and UW_PULSE. There is no drive overlap with oe_n=0.

## Configuration
- DM_UART_EN defined: UART decoding and the UR/UW states are built.
- DM_UART_EN undefined: every address maps to SRAM. uart_rdn and uart_wrn are tied to 1, and the status inputs are unused.

## Structure
- The shared package holds the FSM state encoding, UART_DATA_ADDR and UART_STAT_ADDR, and the status bit positions (bit0 = tx ready, bit1 = rx ready).
- One sub-module, dm_bus_tri, drives ram_data from data_out and data_oe.

## Test plan
- Reset with strobes active mid-write: all strobes read 1 immediately and state returns to IDLE.
- Store 16'h1234 to 16'h0040, then load 16'h0040: ram_we_n low for exactly one cycle, ack after 4 cycles, load returns 16'h1234 with ack after 2 cycles.
- Store 16'h0041 to 16'hBF00 with uart_tsre held low for 5 cycles: wrn pulses once, mem_stall stays high, ack arrives 1 cycle after tsre rises.
- Load 16'hBF01 with data_ready=1, tbre=1, tsre=0: mem_readdata=16'h0002 and ack on the next edge.
- Load 16'hBF00 with bus value 16'hAB5A: mem_readdata=16'h005A and ram_en_n stays 1 throughout.
- mem_read and mem_write both high at 16'h0010: write performed, mem_readdata unchanged. Back-to-back loads give 2 acks with 1 IDLE cycle between them.

Source files
------------

// File: rtl/dm_pkg.sv
// dm_controller shared package: FSM encoding, UART register
// map and status-word layout for the data-memory controller.
package dm_pkg;

  localparam int CPU_W = 16;

  localparam logic [15:0] UART_DATA_ADDR = 16'hBF00;
  localparam logic [15:0] UART_STAT_ADDR = 16'hBF01;

  localparam int STAT_TX_RDY_BIT = 0;
  localparam int STAT_RX_RDY_BIT = 1;

  typedef enum logic [3:0] {
    S_IDLE,
    S_SR_RD,
    S_SW_SET,
    S_SW_PULSE,
    S_SW_HOLD,
    S_UR_PULSE,
    S_UW_PULSE,
    S_UW_WAIT,
    S_DONE
  } dm_state_e;

  typedef enum logic [1:0] {
    SEL_SRAM,
    SEL_UART,
    SEL_STAT
  } dm_sel_e;

  function automatic logic [15:0] stat_word(
    input logic rx_rdy,
    input logic tx_rdy
  );
    logic [15:0] w;
    w = '0;
    w[STAT_RX_RDY_BIT] = rx_rdy;
    w[STAT_TX_RDY_BIT] = tx_rdy;
    return w;
  endfunction

endpackage

// File: rtl/dm_bus_tri.sv
// dm_bus_tri: tri-state driver for the shared SRAM/UART
// data bus; releases the bus whenever data_oe is low.
module dm_bus_tri (
  input  logic [15:0] data_out,
  input  logic        data_oe,
  inout  wire  [15:0] ram_data
);

  assign ram_data = data_oe ? data_out : 16'hzzzz;

endmodule

// File: rtl/dm_controller.sv
// dm_controller: MEM-stage sequencer for Ram1 SRAM and the UART.
// Macro DM_UART_EN builds UART decode and the UR/UW states.
module dm_controller
  import dm_pkg::*;
#(
  parameter int          ADDR_W         = 18,
  parameter logic [15:0] UART_DATA_ADDR = dm_pkg::UART_DATA_ADDR,
  parameter logic [15:0] UART_STAT_ADDR = dm_pkg::UART_STAT_ADDR
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              mem_read,
  input  logic              mem_write,
  input  logic [15:0]       mem_address,
  input  logic [15:0]       mem_wdata,
  output logic [15:0]       mem_readdata,
  output logic              mem_ack,
  output logic              mem_stall,
  output logic [ADDR_W-1:0] ram_addr,
  inout  wire  [15:0]       ram_data,
  output logic              ram_en_n,
  output logic              ram_oe_n,
  output logic              ram_we_n,
  output logic              uart_rdn,
  output logic              uart_wrn,
  input  logic              uart_data_ready,
  input  logic              uart_tbre,
  input  logic              uart_tsre
);

  dm_state_e         state_q;
  logic [15:0]       rdata_q;
  logic              ack_q;
  logic [ADDR_W-1:0] addr_q;
  logic [15:0]       wdata_q;
  logic              drv_q;
  logic              en_n_q;
  logic              oe_n_q;
  logic              we_n_q;

  logic              req;
  dm_sel_e           sel;
  logic [ADDR_W-1:0] addr_ext;

  assign req      = mem_read | mem_write;
  assign addr_ext = {{(ADDR_W-CPU_W){1'b0}}, mem_address};

  // Stall holds EXE/MEM until the ack cycle releases it.
  assign mem_stall = req & ~ack_q;

  assign mem_readdata = rdata_q;
  assign mem_ack      = ack_q;
  assign ram_addr     = addr_q;
  assign ram_en_n     = en_n_q;
  assign ram_oe_n     = oe_n_q;
  assign ram_we_n     = we_n_q;

`ifdef DM_UART_EN
  logic rdn_q;
  logic wrn_q;

  assign uart_rdn = rdn_q;
  assign uart_wrn = wrn_q;

  // Address decode: two UART registers, everything else SRAM.
  always_comb begin
    sel = SEL_SRAM;
    unique case (1'b1)
      (mem_address == UART_DATA_ADDR): sel = SEL_UART;
      (mem_address == UART_STAT_ADDR): sel = SEL_STAT;
      default:                         sel = SEL_SRAM;
    endcase
  end
`else
  logic unused_uart;

  assign uart_rdn = 1'b1;
  assign uart_wrn = 1'b1;
  assign sel      = SEL_SRAM;

  assign unused_uart = ^{uart_data_ready, uart_tbre,
                         uart_tsre, UART_DATA_ADDR,
                         UART_STAT_ADDR};
`endif

  dm_bus_tri u_bus_tri (
    .data_out (wdata_q),
    .data_oe  (drv_q),
    .ram_data (ram_data)
  );

  // Access sequencer; every strobe is a registered output.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= S_IDLE;
      rdata_q <= '0;
      ack_q   <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      drv_q   <= 1'b0;
      en_n_q  <= 1'b1;
      oe_n_q  <= 1'b1;
      we_n_q  <= 1'b1;
`ifdef DM_UART_EN
      rdn_q   <= 1'b1;
      wrn_q   <= 1'b1;
`endif
    end else begin
      unique case (state_q)
        S_IDLE: begin
          ack_q <= 1'b0;
          if (req) begin
            unique case (sel)
`ifdef DM_UART_EN
              SEL_STAT: begin
                // Status is answered without a bus cycle;
                // a store to it is dropped.
                if (!mem_write) begin
                  rdata_q <= stat_word(uart_data_ready,
                                       uart_tbre & uart_tsre);
                end
                ack_q   <= 1'b1;
                state_q <= S_DONE;
              end
              SEL_UART: begin
                if (mem_write) begin
                  wdata_q <= mem_wdata;
                  drv_q   <= 1'b1;
                  wrn_q   <= 1'b0;
                  state_q <= S_UW_PULSE;
                end else begin
                  rdn_q   <= 1'b0;
                  state_q <= S_UR_PULSE;
                end
              end
`endif
              default: begin
                addr_q <= addr_ext;
                en_n_q <= 1'b0;
                if (mem_write) begin
                  wdata_q <= mem_wdata;
                  drv_q   <= 1'b1;
                  state_q <= S_SW_SET;
                end else begin
                  oe_n_q  <= 1'b0;
                  state_q <= S_SR_RD;
                end
              end
            endcase
          end
        end
        S_SR_RD: begin
          rdata_q <= ram_data;
          en_n_q  <= 1'b1;
          oe_n_q  <= 1'b1;
          ack_q   <= 1'b1;
          state_q <= S_DONE;
        end
        S_SW_SET: begin
          we_n_q  <= 1'b0;
          state_q <= S_SW_PULSE;
        end
        S_SW_PULSE: begin
          // Rising we_n latches data while it is still driven.
          we_n_q  <= 1'b1;
          state_q <= S_SW_HOLD;
        end
        S_SW_HOLD: begin
          drv_q   <= 1'b0;
          en_n_q  <= 1'b1;
          ack_q   <= 1'b1;
          state_q <= S_DONE;
        end
`ifdef DM_UART_EN
        S_UR_PULSE: begin
          rdata_q <= {8'h00, ram_data[7:0]};
          rdn_q   <= 1'b1;
          ack_q   <= 1'b1;
          state_q <= S_DONE;
        end
        S_UW_PULSE: begin
          wrn_q   <= 1'b1;
          drv_q   <= 1'b0;
          state_q <= S_UW_WAIT;
        end
        S_UW_WAIT: begin
          // Byte is done only once the shifter drains.
          if (uart_tsre) begin
            ack_q   <= 1'b1;
            state_q <= S_DONE;
          end
        end
`endif
        S_DONE: begin
          ack_q   <= 1'b0;
          state_q <= S_IDLE;
        end
        default: begin
          ack_q   <= 1'b0;
          drv_q   <= 1'b0;
          en_n_q  <= 1'b1;
          oe_n_q  <= 1'b1;
          we_n_q  <= 1'b1;
          state_q <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_dm_controller.sv
// tb_dm_controller: directed bench for dm_controller with an
// SRAM model on the shared bus and a simple UART bus source.
`timescale 1ns/1ps
module tb_dm_controller;

  logic        clk = 1'b0;
  logic        rst;
  logic        mem_read;
  logic        mem_write;
  logic [15:0] mem_address;
  logic [15:0] mem_wdata;
  logic [15:0] mem_readdata;
  logic        mem_ack;
  logic        mem_stall;
  logic [17:0] ram_addr;
  wire  [15:0] ram_data;
  logic        ram_en_n;
  logic        ram_oe_n;
  logic        ram_we_n;
  logic        uart_rdn;
  logic        uart_wrn;
  logic        uart_data_ready;
  logic        uart_tbre;
  logic        uart_tsre;

  logic [15:0] mem [0:255];
  logic [15:0] uart_bus;

  int pass_cnt = 0;
  int chk_cnt  = 0;
  int we_low   = 0;
  int wrn_falls = 0;
  int excl_err = 0;
  logic wrn_prev = 1'b1;

  dm_controller dut (
    .clk             (clk),
    .rst             (rst),
    .mem_read        (mem_read),
    .mem_write       (mem_write),
    .mem_address     (mem_address),
    .mem_wdata       (mem_wdata),
    .mem_readdata    (mem_readdata),
    .mem_ack         (mem_ack),
    .mem_stall       (mem_stall),
    .ram_addr        (ram_addr),
    .ram_data        (ram_data),
    .ram_en_n        (ram_en_n),
    .ram_oe_n        (ram_oe_n),
    .ram_we_n        (ram_we_n),
    .uart_rdn        (uart_rdn),
    .uart_wrn        (uart_wrn),
    .uart_data_ready (uart_data_ready),
    .uart_tbre       (uart_tbre),
    .uart_tsre       (uart_tsre)
  );

  always #5 clk = ~clk;

  assign ram_data = (!ram_en_n && !ram_oe_n) ? mem[ram_addr[7:0]] :
                    (!uart_rdn ? uart_bus : 16'hzzzz);

  always @(posedge clk) begin
    if (!ram_en_n && !ram_we_n) mem[ram_addr[7:0]] <= ram_data;
  end

  always @(posedge clk) begin
    if (!ram_we_n) we_low++;
    if (!ram_en_n && (!uart_rdn || !uart_wrn)) excl_err++;
    if (wrn_prev && !uart_wrn) wrn_falls++;
    wrn_prev = uart_wrn;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  task automatic start_req(input logic r, input logic w,
                           input logic [15:0] a,
                           input logic [15:0] d);
    @(negedge clk);
    mem_read    = r;
    mem_write   = w;
    mem_address = a;
    mem_wdata   = d;
  endtask

  task automatic end_req();
    mem_read  = 1'b0;
    mem_write = 1'b0;
  endtask

  task automatic wait_ack(output int cyc);
    cyc = 0;
    do begin
      @(posedge clk);
      cyc++;
      @(negedge clk);
    end while (!mem_ack && cyc < 40);
  endtask

  task automatic test_reset();
    rst = 1'b0;
    end_req();
    mem_address = '0;
    mem_wdata = '0;
    repeat (2) @(negedge clk);
    chk_cnt++;
    if ({mem_ack, mem_readdata, ram_addr} !== 35'd0)
      $display("FAIL reset_regs: ack=%b rdata=%h addr=%h want 0",
               mem_ack, mem_readdata, ram_addr);
    else pass_cnt++;
    chk_cnt++;
    if ({ram_en_n, ram_oe_n, ram_we_n, uart_rdn, uart_wrn}
        !== 5'b11111)
      $display("FAIL reset_strobes: got %b want 11111",
               {ram_en_n, ram_oe_n, ram_we_n, uart_rdn, uart_wrn});
    else pass_cnt++;
    chk_cnt++;
    if (mem_stall !== 1'b0)
      $display("FAIL reset_stall: got %b want 0", mem_stall);
    else pass_cnt++;
    rst = 1'b1;
  endtask

  task automatic test_reset_mid_write();
    int cyc;
    start_req(1'b0, 1'b1, 16'h0020, 16'h5555);
    @(posedge clk);
    @(posedge clk);
    #1;
    chk_cnt++;
    if (ram_we_n !== 1'b0)
      $display("FAIL midwr_we_low: got %b want 0", ram_we_n);
    else pass_cnt++;
    rst = 1'b0;
    #1;
    chk_cnt++;
    if ({ram_en_n, ram_oe_n, ram_we_n, uart_rdn, uart_wrn,
         mem_ack} !== 6'b111110)
      $display("FAIL midwr_async: got %b want 111110",
               {ram_en_n, ram_oe_n, ram_we_n, uart_rdn, uart_wrn,
                mem_ack});
    else pass_cnt++;
    @(negedge clk);
    end_req();
    rst = 1'b1;
    @(negedge clk);
    chk_cnt++;
    if (mem_ack !== 1'b0)
      $display("FAIL midwr_no_ack: got %b want 0", mem_ack);
    else pass_cnt++;
    start_req(1'b1, 1'b0, 16'h0030, 16'h0000);
    wait_ack(cyc);
    chk_cnt++;
    if (cyc !== 2 || mem_readdata !== 16'hC0DE)
      $display("FAIL midwr_recover: cyc=%0d data=%h want 2 c0de",
               cyc, mem_readdata);
    else pass_cnt++;
    end_req();
  endtask

  task automatic test_sram_store_load();
    int cyc;
    we_low = 0;
    start_req(1'b0, 1'b1, 16'h0040, 16'h1234);
    #1;
    chk_cnt++;
    if (mem_stall !== 1'b1)
      $display("FAIL sw_stall: got %b want 1", mem_stall);
    else pass_cnt++;
    wait_ack(cyc);
    chk_cnt++;
    if (cyc !== 4)
      $display("FAIL sw_latency: got %0d want 4", cyc);
    else pass_cnt++;
    chk_cnt++;
    if (mem_stall !== 1'b0)
      $display("FAIL sw_stall_ack: got %b want 0", mem_stall);
    else pass_cnt++;
    end_req();
    chk_cnt++;
    if (we_low !== 1)
      $display("FAIL sw_we_pulse: got %0d cycles want 1", we_low);
    else pass_cnt++;
    start_req(1'b1, 1'b0, 16'h0040, 16'h0000);
    wait_ack(cyc);
    chk_cnt++;
    if (cyc !== 2 || mem_readdata !== 16'h1234)
      $display("FAIL sr_load: cyc=%0d data=%h want 2 1234",
               cyc, mem_readdata);
    else pass_cnt++;
    end_req();
  endtask

  task automatic test_read_write_both();
    int cyc;
    start_req(1'b1, 1'b1, 16'h0010, 16'hBEEF);
    wait_ack(cyc);
    chk_cnt++;
    if (cyc !== 4 || mem_readdata !== 16'h1234)
      $display("FAIL both_rw: cyc=%0d data=%h want 4 1234",
               cyc, mem_readdata);
    else pass_cnt++;
    end_req();
    @(negedge clk);
    chk_cnt++;
    if (mem[16] !== 16'hBEEF)
      $display("FAIL both_rw_mem: got %h want beef", mem[16]);
    else pass_cnt++;
  endtask

  task automatic test_back_to_back();
    int cyc;
    start_req(1'b1, 1'b0, 16'h0040, 16'h0000);
    wait_ack(cyc);
    chk_cnt++;
    if (cyc !== 2 || mem_readdata !== 16'h1234)
      $display("FAIL b2b_first: cyc=%0d data=%h want 2 1234",
               cyc, mem_readdata);
    else pass_cnt++;
    mem_address = 16'h0010;
    @(negedge clk);
    chk_cnt++;
    if (mem_ack !== 1'b0 || ram_en_n !== 1'b1)
      $display("FAIL b2b_idle_gap: ack=%b en_n=%b want 0 1",
               mem_ack, ram_en_n);
    else pass_cnt++;
    wait_ack(cyc);
    chk_cnt++;
    if (cyc !== 2 || mem_readdata !== 16'hBEEF)
      $display("FAIL b2b_second: cyc=%0d data=%h want 2 beef",
               cyc, mem_readdata);
    else pass_cnt++;
    end_req();
  endtask

`ifdef DM_UART_EN
  task automatic test_uart_write();
    int bad;
    bad = 0;
    uart_tsre = 1'b0;
    wrn_falls = 0;
    start_req(1'b0, 1'b1, 16'hBF00, 16'h0041);
    repeat (5) begin
      @(posedge clk);
      @(negedge clk);
      if (!mem_stall || mem_ack) bad++;
    end
    chk_cnt++;
    if (bad !== 0)
      $display("FAIL uw_stall_hold: bad cycles %0d want 0", bad);
    else pass_cnt++;
    uart_tsre = 1'b1;
    @(posedge clk);
    @(negedge clk);
    chk_cnt++;
    if (mem_ack !== 1'b1)
      $display("FAIL uw_ack_after_tsre: got %b want 1", mem_ack);
    else pass_cnt++;
    end_req();
    chk_cnt++;
    if (wrn_falls !== 1)
      $display("FAIL uw_wrn_pulses: got %0d want 1", wrn_falls);
    else pass_cnt++;
  endtask

  task automatic test_stat_read();
    int cyc;
    uart_data_ready = 1'b1;
    uart_tbre = 1'b1;
    uart_tsre = 1'b0;
    start_req(1'b1, 1'b0, 16'hBF01, 16'h0000);
    wait_ack(cyc);
    chk_cnt++;
    if (cyc !== 1 || mem_readdata !== 16'h0002)
      $display("FAIL stat_read: cyc=%0d data=%h want 1 0002",
               cyc, mem_readdata);
    else pass_cnt++;
    end_req();
    uart_tsre = 1'b1;
  endtask

  task automatic test_uart_read();
    uart_bus = 16'hAB5A;
    start_req(1'b1, 1'b0, 16'hBF00, 16'h0000);
    @(posedge clk);
    @(negedge clk);
    chk_cnt++;
    if (uart_rdn !== 1'b0 || ram_en_n !== 1'b1)
      $display("FAIL ur_pulse: rdn=%b en_n=%b want 0 1",
               uart_rdn, ram_en_n);
    else pass_cnt++;
    @(posedge clk);
    @(negedge clk);
    chk_cnt++;
    if (mem_ack !== 1'b1 || mem_readdata !== 16'h005A ||
        ram_en_n !== 1'b1)
      $display("FAIL ur_data: ack=%b data=%h en_n=%b want 1 005a 1",
               mem_ack, mem_readdata, ram_en_n);
    else pass_cnt++;
    end_req();
  endtask
`else
  task automatic test_no_uart();
    int cyc;
    wrn_falls = 0;
    start_req(1'b0, 1'b1, 16'hBF00, 16'h0041);
    wait_ack(cyc);
    chk_cnt++;
    if (cyc !== 4 || wrn_falls !== 0)
      $display("FAIL nouart_store: cyc=%0d wrn_falls=%0d want 4 0",
               cyc, wrn_falls);
    else pass_cnt++;
    end_req();
    start_req(1'b1, 1'b0, 16'hBF00, 16'h0000);
    wait_ack(cyc);
    chk_cnt++;
    if (cyc !== 2 || mem_readdata !== 16'h0041 ||
        uart_rdn !== 1'b1)
      $display("FAIL nouart_load: cyc=%0d data=%h rdn=%b want 2 0041 1",
               cyc, mem_readdata, uart_rdn);
    else pass_cnt++;
    end_req();
  endtask
`endif

  initial begin
    for (int i = 0; i < 256; i++) mem[i] = 16'h0000;
    mem[8'h30] = 16'hC0DE;
    uart_bus = 16'h0000;
    uart_data_ready = 1'b0;
    uart_tbre = 1'b1;
    uart_tsre = 1'b1;
    test_reset();
    test_reset_mid_write();
    test_sram_store_load();
    test_read_write_both();
    test_back_to_back();
`ifdef DM_UART_EN
    test_uart_write();
    test_stat_read();
    test_uart_read();
`else
    test_no_uart();
`endif
    @(negedge clk);
    chk_cnt++;
    if (excl_err !== 0)
      $display("FAIL sram_uart_overlap: got %0d cycles want 0",
               excl_err);
    else pass_cnt++;
    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

endmodule
